cam_lut_update: RTL and testbench

Update engine for the LUTRAM-based match cells: takes entry write/invalidate requests and regenerates the contents of the four 64-deep slice LUTRAMs (a, b, c, d), one address per cycle, from a shadow key table. It is the write side of the match array. The search side reads the same LUTRAMs and ANDs the four slice outputs along the carry chain. Searches must be held off while `busy` is high.

---
 rtl/cam_lut_update_if.sv | 14 +
 rtl/cam_lut_update.sv | 155 +++++++++++++++
 tb/tb_cam_lut_update.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_lut_update_if.sv
// Request channel into the CAM LUTRAM update engine: entry write/invalidate
// requests with a valid/ready handshake.
interface cam_lut_update_if #(
    parameter int IDX_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic             req_op;
    logic [IDX_W-1:0] req_idx;
    logic [23:0]      req_key;

    modport master (output req_valid, req_op, req_idx, req_key, input req_ready);
    modport slave  (input req_valid, req_op, req_idx, req_key, output req_ready);
endinterface

// File: rtl/cam_lut_update.sv
// Write side of the LUTRAM match array: keeps a shadow key table and rebuilds
// all 64 words of the four slice LUTRAMs after every accepted request.
module cam_lut_update #(
    parameter int ENTRIES = 32,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic               clk,
    input  logic               rst_n,
    cam_lut_update_if.slave    req,
    output logic               lut_we,
    output logic [5:0]         lut_addr,
    output logic [ENTRIES-1:0] lut_din_a,
    output logic [ENTRIES-1:0] lut_din_b,
    output logic [ENTRIES-1:0] lut_din_c,
    output logic [ENTRIES-1:0] lut_din_d,
    output logic               busy,
    output logic               done
);
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SWEEP = 2'd2
    } state_t;

    state_t             state_r, state_nx_s;
    logic [5:0]         cnt_r, cnt_nx_s;
    logic [ENTRIES-1:0] valid_r, valid_nx_s;
    logic [23:0]        key_r    [ENTRIES];
    logic [23:0]        key_nx_s [ENTRIES];
    logic               done_pend_r, done_pend_nx_s;
    logic               ready_r, ready_nx_s;
    logic               we_nx_s, busy_nx_s, done_nx_s, fill_s;
    logic [5:0]         addr_nx_s;
    logic [ENTRIES-1:0] din_a_nx_s, din_b_nx_s, din_c_nx_s, din_d_nx_s;

    assign req.req_ready = ready_r;

    // Next state, shadow-table update and next output values.
    always_comb begin
        state_nx_s     = state_r;
        cnt_nx_s       = cnt_r;
        valid_nx_s     = valid_r;
        key_nx_s       = key_r;
        done_pend_nx_s = done_pend_r;
        we_nx_s        = 1'b0;
        addr_nx_s      = lut_addr;
        busy_nx_s      = 1'b1;
        ready_nx_s     = 1'b0;
        done_nx_s      = 1'b0;
        fill_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req.req_valid && ready_r) begin
                    // Out-of-range indices match no entry and leave the table as is.
                    for (int e = 0; e < ENTRIES; e++) begin
                        if (req.req_idx == IDX_W'(e)) begin
                            valid_nx_s[e] = req.req_op;
                            if (req.req_op) begin
                                key_nx_s[e] = req.req_key;
                            end else begin
                                key_nx_s[e] = key_r[e];
                            end
                        end else begin
                            valid_nx_s[e] = valid_r[e];
                        end
                    end
                    state_nx_s = ST_SWEEP;
                    cnt_nx_s   = 6'd1;
                    we_nx_s    = 1'b1;
                    addr_nx_s  = 6'd0;
                    fill_s     = 1'b1;
                end else begin
                    busy_nx_s      = 1'b0;
                    ready_nx_s     = 1'b1;
                    done_nx_s      = done_pend_r;
                    done_pend_nx_s = 1'b0;
                end
            end
            ST_INIT, ST_SWEEP: begin
                we_nx_s   = 1'b1;
                addr_nx_s = cnt_r;
                cnt_nx_s  = cnt_r + 6'd1;
                fill_s    = (state_r == ST_SWEEP);
                if (cnt_r == 6'd63) begin
                    state_nx_s     = ST_IDLE;
                    done_pend_nx_s = (state_r == ST_SWEEP);
                end else begin
                    state_nx_s = state_r;
                end
            end
            default: begin
                state_nx_s = ST_INIT;
                cnt_nx_s   = 6'd0;
            end
        endcase

        if (we_nx_s) begin
            for (int e = 0; e < ENTRIES; e++) begin
                din_a_nx_s[e] = fill_s && valid_nx_s[e] && (key_nx_s[e][5:0]   == addr_nx_s);
                din_b_nx_s[e] = fill_s && valid_nx_s[e] && (key_nx_s[e][11:6]  == addr_nx_s);
                din_c_nx_s[e] = fill_s && valid_nx_s[e] && (key_nx_s[e][17:12] == addr_nx_s);
                din_d_nx_s[e] = fill_s && valid_nx_s[e] && (key_nx_s[e][23:18] == addr_nx_s);
            end
        end else begin
            din_a_nx_s = lut_din_a;
            din_b_nx_s = lut_din_b;
            din_c_nx_s = lut_din_c;
            din_d_nx_s = lut_din_d;
        end
    end

    // FSM state, sweep counter and shadow key table.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_INIT;
            cnt_r       <= 6'd0;
            valid_r     <= {ENTRIES{1'b0}};
            done_pend_r <= 1'b0;
            for (int e = 0; e < ENTRIES; e++) begin
                key_r[e] <= 24'd0;
            end
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            valid_r     <= valid_nx_s;
            done_pend_r <= done_pend_nx_s;
            key_r       <= key_nx_s;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lut_we    <= 1'b0;
            lut_addr  <= 6'd0;
            lut_din_a <= {ENTRIES{1'b0}};
            lut_din_b <= {ENTRIES{1'b0}};
            lut_din_c <= {ENTRIES{1'b0}};
            lut_din_d <= {ENTRIES{1'b0}};
            ready_r   <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
        end else begin
            lut_we    <= we_nx_s;
            lut_addr  <= addr_nx_s;
            lut_din_a <= din_a_nx_s;
            lut_din_b <= din_b_nx_s;
            lut_din_c <= din_c_nx_s;
            lut_din_d <= din_d_nx_s;
            ready_r   <= ready_nx_s;
            busy      <= busy_nx_s;
            done      <= done_nx_s;
        end
    end
endmodule

// File: tb/tb_cam_lut_update.sv
// Directed bench for cam_lut_update: mirrors LUTRAM writes and searches the
// mirror to confirm the match array contents after each request.
module tb_cam_lut_update;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lut_we;
    logic [5:0]  lut_addr;
    logic [31:0] lut_din_a, lut_din_b, lut_din_c, lut_din_d;
    logic        busy, done;
    int          pass_cnt = 0;
    int          check_cnt = 0;
    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];
    logic [31:0] mem_c [64];
    logic [31:0] mem_d [64];

    cam_lut_update_if #(.IDX_W(5)) rq ();

    cam_lut_update #(.ENTRIES(32), .IDX_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (rq),
        .lut_we    (lut_we),
        .lut_addr  (lut_addr),
        .lut_din_a (lut_din_a),
        .lut_din_b (lut_din_b),
        .lut_din_c (lut_din_c),
        .lut_din_d (lut_din_d),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Mirror of the four LUTRAMs, filled from observed writes.
    always @(negedge clk) begin
        if (lut_we === 1'b1) begin
            mem_a[lut_addr] = lut_din_a;
            mem_b[lut_addr] = lut_din_b;
            mem_c[lut_addr] = lut_din_c;
            mem_d[lut_addr] = lut_din_d;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] search(input logic [23:0] k);
        return mem_a[k[5:0]] & mem_b[k[11:6]] & mem_c[k[17:12]] & mem_d[k[23:18]];
    endfunction

    function automatic int mirror_ones();
        int s = 0;
        for (int i = 0; i < 64; i++)
            s += $countones(mem_a[i]) + $countones(mem_b[i]) + $countones(mem_c[i]) + $countones(mem_d[i]);
        return s;
    endfunction

    task automatic send_req(input logic op, input logic [4:0] idx, input logic [23:0] key, output bit ok);
        rq.req_op = op;
        rq.req_idx = idx;
        rq.req_key = key;
        rq.req_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 300 && !ok; n++) begin
            if (rq.req_ready === 1'b1) ok = 1'b1;
            @(negedge clk);
        end
        rq.req_valid = 1'b0;
    endtask

    task automatic count_sweep(output int nwr, output int ndone, output int nbad);
        nwr = 0; ndone = 0; nbad = 0;
        for (int i = 0; i < 66; i++) begin
            if (lut_we === 1'b1) begin
                if (lut_addr !== 6'(nwr)) nbad++;
                nwr++;
            end
            if (done === 1'b1) ndone++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        @(negedge clk);
        @(negedge clk);
        check_cnt++; if (lut_we !== 1'b0) $display("FAIL rst_we: got %0h want 0", lut_we); else pass_cnt++;
        check_cnt++; if (lut_addr !== 6'd0) $display("FAIL rst_addr: got %0h want 0", lut_addr); else pass_cnt++;
        check_cnt++; if ((lut_din_a | lut_din_b | lut_din_c | lut_din_d) !== 32'd0) $display("FAIL rst_din: got nonzero word"); else pass_cnt++;
        check_cnt++; if (rq.req_ready !== 1'b0) $display("FAIL rst_ready: got %0h want 0", rq.req_ready); else pass_cnt++;
        check_cnt++; if (busy !== 1'b1) $display("FAIL rst_busy: got %0h want 1", busy); else pass_cnt++;
        check_cnt++; if (done !== 1'b0) $display("FAIL rst_done: got %0h want 0", done); else pass_cnt++;
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!(lut_we === 1'b1 && lut_addr === 6'(i) && busy === 1'b1 && rq.req_ready === 1'b0 &&
                  (lut_din_a | lut_din_b | lut_din_c | lut_din_d) === 32'd0)) bad++;
        end
        check_cnt++; if (bad != 0) $display("FAIL init_sweep: %0d bad cycles, want 0", bad); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (rq.req_ready !== 1'b1) $display("FAIL init_ready65: got %0h want 1", rq.req_ready); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0 || lut_we !== 1'b0 || done !== 1'b0)
            $display("FAIL init_idle: busy=%0h we=%0h done=%0h want 0/0/0", busy, lut_we, done); else pass_cnt++;
        check_cnt++; if (search(24'h000000) !== 32'd0) $display("FAIL init_search0: got %h want 0", search(24'h000000)); else pass_cnt++;
        check_cnt++; if (mirror_ones() != 0) $display("FAIL init_clear: got %0d set bits want 0", mirror_ones()); else pass_cnt++;
    endtask

    task automatic test_write_entry3();
        bit ok;
        int bad = 0;
        send_req(1'b1, 5'd3, 24'h00C841, ok);
        check_cnt++; if (!ok) $display("FAIL w3_handshake: got timeout want accept"); else pass_cnt++;
        check_cnt++; if (lut_we !== 1'b1 || lut_addr !== 6'd0 || busy !== 1'b1 || rq.req_ready !== 1'b0)
            $display("FAIL w3_first: we=%0h addr=%0h busy=%0h ready=%0h want 1/0/1/0", lut_we, lut_addr, busy, rq.req_ready); else pass_cnt++;
        for (int i = 1; i < 64; i++) begin
            @(negedge clk);
            if (!(lut_we === 1'b1 && lut_addr === 6'(i) && done === 1'b0)) bad++;
        end
        check_cnt++; if (bad != 0) $display("FAIL w3_sweep: %0d bad cycles want 0", bad); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (done !== 1'b1 || lut_we !== 1'b0 || busy !== 1'b0 || rq.req_ready !== 1'b1)
            $display("FAIL w3_done: done=%0h we=%0h busy=%0h ready=%0h want 1/0/0/1", done, lut_we, busy, rq.req_ready); else pass_cnt++;
        check_cnt++; if (lut_addr !== 6'd63) $display("FAIL w3_addr_hold: got %0h want 3f", lut_addr); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (done !== 1'b0) $display("FAIL w3_done_pulse: got %0h want 0", done); else pass_cnt++;
        check_cnt++; if (mem_a[6'h01] !== 32'h8 || mem_b[6'h21] !== 32'h8 || mem_c[6'h0C] !== 32'h8 || mem_d[6'h00] !== 32'h8)
            $display("FAIL w3_words: a=%h b=%h c=%h d=%h want 8 each", mem_a[6'h01], mem_b[6'h21], mem_c[6'h0C], mem_d[6'h00]); else pass_cnt++;
        check_cnt++; if (mirror_ones() != 4) $display("FAIL w3_ones: got %0d want 4", mirror_ones()); else pass_cnt++;
        check_cnt++; if (search(24'h00C841) !== 32'h8) $display("FAIL w3_search: got %h want 8", search(24'h00C841)); else pass_cnt++;
    endtask

    task automatic test_dup_invalidate();
        bit ok;
        int nwr, ndone, nbad;
        send_req(1'b1, 5'd5, 24'h00C841, ok);
        count_sweep(nwr, ndone, nbad);
        check_cnt++; if (!ok || nwr != 64 || ndone != 1 || nbad != 0)
            $display("FAIL dup_sweep: ok=%0d wr=%0d done=%0d bad=%0d want 1/64/1/0", ok, nwr, ndone, nbad); else pass_cnt++;
        check_cnt++; if (search(24'h00C841) !== 32'h28) $display("FAIL dup_search: got %h want 28", search(24'h00C841)); else pass_cnt++;
        send_req(1'b0, 5'd3, 24'h000000, ok);
        count_sweep(nwr, ndone, nbad);
        check_cnt++; if (!ok || nwr != 64 || ndone != 1 || nbad != 0)
            $display("FAIL inv3_sweep: ok=%0d wr=%0d done=%0d bad=%0d want 1/64/1/0", ok, nwr, ndone, nbad); else pass_cnt++;
        check_cnt++; if (mem_a[6'h01] !== 32'h20 || mem_b[6'h21] !== 32'h20 || mem_c[6'h0C] !== 32'h20 || mem_d[6'h00] !== 32'h20)
            $display("FAIL inv3_words: a=%h b=%h c=%h d=%h want 20 each", mem_a[6'h01], mem_b[6'h21], mem_c[6'h0C], mem_d[6'h00]); else pass_cnt++;
        check_cnt++; if (mirror_ones() != 4) $display("FAIL inv3_ones: got %0d want 4", mirror_ones()); else pass_cnt++;
    endtask

    task automatic test_rewrite();
        bit ok;
        int nwr, ndone, nbad;
        send_req(1'b1, 5'd5, 24'hFFFFFF, ok);
        count_sweep(nwr, ndone, nbad);
        check_cnt++; if (!ok || nwr != 64 || ndone != 1 || nbad != 0)
            $display("FAIL rw_sweep: ok=%0d wr=%0d done=%0d bad=%0d want 1/64/1/0", ok, nwr, ndone, nbad); else pass_cnt++;
        check_cnt++; if (mem_a[63] !== 32'h20 || mem_b[63] !== 32'h20 || mem_c[63] !== 32'h20 || mem_d[63] !== 32'h20)
            $display("FAIL rw_new: a=%h b=%h c=%h d=%h want 20 each", mem_a[63], mem_b[63], mem_c[63], mem_d[63]); else pass_cnt++;
        check_cnt++; if ((mem_a[6'h01] | mem_b[6'h21] | mem_c[6'h0C] | mem_d[6'h00]) !== 32'd0)
            $display("FAIL rw_old: a=%h b=%h c=%h d=%h want 0", mem_a[6'h01], mem_b[6'h21], mem_c[6'h0C], mem_d[6'h00]); else pass_cnt++;
        check_cnt++; if (search(24'h00C841) !== 32'd0) $display("FAIL rw_oldkey: got %h want 0", search(24'h00C841)); else pass_cnt++;
        send_req(1'b0, 5'd3, 24'h000000, ok);
        count_sweep(nwr, ndone, nbad);
        check_cnt++; if (!ok || nwr != 64 || ndone != 1 || nbad != 0)
            $display("FAIL reinv_sweep: ok=%0d wr=%0d done=%0d bad=%0d want 1/64/1/0", ok, nwr, ndone, nbad); else pass_cnt++;
        check_cnt++; if (search(24'hFFFFFF) !== 32'h20 || mirror_ones() != 4)
            $display("FAIL reinv_keep: search=%h ones=%0d want 20/4", search(24'hFFFFFF), mirror_ones()); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic        ops  [3];
        logic [4:0]  idxs [3];
        logic [23:0] keys [3];
        int hs [3];
        int n = 0, ndone = 0;
        bit adv = 1'b0;
        ops[0] = 1'b1; idxs[0] = 5'd7; keys[0] = 24'h123456;
        ops[1] = 1'b1; idxs[1] = 5'd8; keys[1] = 24'h654321;
        ops[2] = 1'b0; idxs[2] = 5'd7; keys[2] = 24'h000000;
        hs[0] = 0; hs[1] = 0; hs[2] = 0;
        rq.req_op = ops[0]; rq.req_idx = idxs[0]; rq.req_key = keys[0]; rq.req_valid = 1'b1;
        for (int k = 0; k < 260; k++) begin
            if (adv) begin
                if (n < 3) begin
                    rq.req_op = ops[n]; rq.req_idx = idxs[n]; rq.req_key = keys[n];
                end else begin
                    rq.req_valid = 1'b0;
                end
                adv = 1'b0;
            end
            if (done === 1'b1) ndone++;
            if (rq.req_ready === 1'b1 && rq.req_valid === 1'b1 && n < 3) begin
                hs[n] = k;
                n++;
                adv = 1'b1;
            end
            @(negedge clk);
        end
        rq.req_valid = 1'b0;
        check_cnt++; if (n != 3) $display("FAIL b2b_count: got %0d handshakes want 3", n); else pass_cnt++;
        check_cnt++; if (hs[1] - hs[0] != 65) $display("FAIL b2b_gap1: got %0d want 65", hs[1] - hs[0]); else pass_cnt++;
        check_cnt++; if (hs[2] - hs[1] != 65) $display("FAIL b2b_gap2: got %0d want 65", hs[2] - hs[1]); else pass_cnt++;
        check_cnt++; if (ndone != 3) $display("FAIL b2b_done: got %0d want 3", ndone); else pass_cnt++;
        check_cnt++; if (search(24'h123456) !== 32'd0) $display("FAIL b2b_inv7: got %h want 0", search(24'h123456)); else pass_cnt++;
        check_cnt++; if (search(24'h654321) !== 32'h100) $display("FAIL b2b_w8: got %h want 100", search(24'h654321)); else pass_cnt++;
        check_cnt++; if (search(24'hFFFFFF) !== 32'h20) $display("FAIL b2b_keep5: got %h want 20", search(24'hFFFFFF)); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit found = 1'b0;
        int bad = 0, ndone = 0;
        send_req(1'b1, 5'd9, 24'h0A0A0A, ok);
        for (int i = 0; i < 40 && !found; i++) begin
            if (lut_addr === 6'd20) found = 1'b1;
            else @(negedge clk);
        end
        check_cnt++; if (!ok || !found) $display("FAIL mid_reach20: ok=%0d found=%0d want 1/1", ok, found); else pass_cnt++;
        rst_n = 1'b0;
        @(negedge clk);
        check_cnt++; if (lut_we !== 1'b0 || lut_addr !== 6'd0 || busy !== 1'b1 || rq.req_ready !== 1'b0 || done !== 1'b0)
            $display("FAIL mid_rst: we=%0h addr=%0h busy=%0h ready=%0h done=%0h want 0/0/1/0/0",
                     lut_we, lut_addr, busy, rq.req_ready, done); else pass_cnt++;
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
            if (!(lut_we === 1'b1 && lut_addr === 6'(i) && (lut_din_a | lut_din_b | lut_din_c | lut_din_d) === 32'd0)) bad++;
        end
        @(negedge clk);
        if (done === 1'b1) ndone++;
        check_cnt++; if (bad != 0) $display("FAIL mid_init: %0d bad cycles want 0", bad); else pass_cnt++;
        check_cnt++; if (ndone != 0) $display("FAIL mid_nodone: got %0d pulses want 0", ndone); else pass_cnt++;
        check_cnt++; if (rq.req_ready !== 1'b1 || busy !== 1'b0) $display("FAIL mid_idle: ready=%0h busy=%0h want 1/0", rq.req_ready, busy); else pass_cnt++;
        check_cnt++; if (mirror_ones() != 0) $display("FAIL mid_clear: got %0d set bits want 0", mirror_ones()); else pass_cnt++;
        check_cnt++; if (search(24'h0A0A0A) !== 32'd0) $display("FAIL mid_search: got %h want 0", search(24'h0A0A0A)); else pass_cnt++;
    endtask

    initial begin
        rq.req_valid = 1'b0;
        rq.req_op = 1'b0;
        rq.req_idx = 5'd0;
        rq.req_key = 24'd0;
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = '1; mem_b[i] = '1; mem_c[i] = '1; mem_d[i] = '1;
        end
        test_reset();
        test_write_entry3();
        test_dup_invalidate();
        test_rewrite();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
